// File: rtl/lru_button_front.sv
// lru_button_front: input stage for the 4-entry LRU block.
//
// Each of four raw push-button levels is synchronised, then debounced on
// timer ticks. Every accepted 0->1 transition of a debounced level becomes
// exactly one access request. Outstanding requests are issued one at a
// time, lowest index first.
//
// Handshake: req_valid/req_id are registered. Once req_valid is high,
// req_valid and req_id hold until the cycle in which req_ready is also high.
// That cycle is the transfer. req_ready is ignored while req_valid is low.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   tick       one-cycle debounce sample strobe
//   b1..b4     raw asynchronous button levels
//   d1..d4     debounced button levels (register outputs)
//   req_valid  request offered
//   req_id     offered entry, 0=b1 .. 3=b4
//   req_ready  consumer accepts the offered request
//   overrun    sticky: a press arrived while its entry was already pending
module lru_button_front #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic       req_valid,
  output logic [1:0] req_id,
  input  logic       req_ready,
  output logic       overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Count value at which the next differing tick accepts the new level.
  localparam logic [CNT_W-1:0] TICKS_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  state_t                 state, state_next;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [3:0]             s;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_next;
  logic [3:0]             d_q, d_next;
  logic [3:0]             rise;
  logic [3:0]             pending, pending_next;
  logic [3:0]             pop;
  logic                   valid_next;
  logic [1:0]             id_next;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chains, all four buttons side by side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= {b4, b3, b2, b1};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce: a differing level must be seen on DEBOUNCE_TICKS consecutive
  // ticks; any tick that sees agreement restarts the count.
  always_comb begin
    d_next   = d_q;
    cnt_next = cnt_q;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == d_q[i]) begin
          cnt_next[i] = '0;
        end else if (cnt_q[i] == TICKS_LAST) begin
          d_next[i]   = s[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Taken from the next-state value so the pending bit sets on the same
  // edge that the debounced level rises.
  assign rise = d_next & ~d_q;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest = 2'(i);
    end
  endfunction

  // Arbiter. Only bits already registered in pending are eligible, so a
  // press arriving on the same edge waits at least one cycle.
  always_comb begin
    state_next = state;
    valid_next = req_valid;
    id_next    = req_id;
    pop        = 4'b0000;
    case (state)
      IDLE: begin
        if (pending != 4'b0000) begin
          id_next    = lowest(pending);
          pop        = 4'b0001 << lowest(pending);
          valid_next = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (req_ready) begin
          if (pending != 4'b0000) begin
            id_next = lowest(pending);
            pop     = 4'b0001 << lowest(pending);
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Set wins over pop when both hit the same bit on one edge.
  assign pending_next = (pending & ~pop) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      d_q       <= '0;
      pending   <= '0;
      req_valid <= 1'b0;
      req_id    <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt_q     <= cnt_next;
      d_q       <= d_next;
      pending   <= pending_next;
      req_valid <= valid_next;
      req_id    <= id_next;
      // An entry already in the offer slot is not pending, so a new press
      // for it is queued rather than flagged.
      if ((rise & pending) != 4'b0000) overrun <= 1'b1;
    end
  end

  assign d1 = d_q[0];
  assign d2 = d_q[1];
  assign d3 = d_q[2];
  assign d4 = d_q[3];

endmodule

// File: tb/tb_lru_button_front.sv
module tb_lru_button_front;

  localparam int SYNC_STAGES    = 2;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int CNT_W          = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       b1, b2, b3, b4;
  logic       d1, d2, d3, d4;
  logic       req_valid;
  logic [1:0] req_id;
  logic       req_ready;
  logic       overrun;

  always #5 clk = ~clk;

  lru_button_front #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .overrun(overrun)
  );

  logic [3:0] d_all;
  assign d_all = {d4, d3, d2, d1};

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Buttons are delayed by the synchroniser depth; each debounced level
  // changes after DEBOUNCE_TICKS consecutive disagreeing ticks; a rising
  // level adds its index to the outstanding set; the offer slot is free
  // when empty or when its request is taken, and is refilled from the
  // lowest outstanding index.
  logic [3:0] m_sync [SYNC_STAGES];
  logic [3:0] m_d, m_pend;
  int         m_cnt [4];
  logic       m_valid, m_ovr;
  logic [1:0] m_id;

  logic [3:0] mt_s, mt_d, mt_rise, mt_pend;
  int         mt_cnt [4];
  logic       mt_valid, mt_ovr;
  logic [1:0] mt_id;

  always_comb begin
    mt_s = m_sync[SYNC_STAGES-1];
    mt_d = m_d;
    for (int i = 0; i < 4; i++) begin
      mt_cnt[i] = m_cnt[i];
      if (tick) begin
        if (mt_s[i] == m_d[i]) begin
          mt_cnt[i] = 0;
        end else if (m_cnt[i] + 1 == DEBOUNCE_TICKS) begin
          mt_d[i]   = mt_s[i];
          mt_cnt[i] = 0;
        end else begin
          mt_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    mt_rise  = mt_d & ~m_d;
    mt_pend  = m_pend;
    mt_valid = m_valid;
    mt_id    = m_id;
    if (!m_valid || req_ready) begin
      mt_valid = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        if (m_pend[i]) begin
          mt_id    = 2'(i);
          mt_valid = 1'b1;
        end
      end
      if (mt_valid) mt_pend[mt_id] = 1'b0;
    end
    mt_pend = mt_pend | mt_rise;
    mt_ovr  = m_ovr | (|(mt_rise & m_pend));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) m_sync[k] <= 4'b0000;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      m_d     <= 4'b0000;
      m_pend  <= 4'b0000;
      m_valid <= 1'b0;
      m_id    <= 2'd0;
      m_ovr   <= 1'b0;
    end else begin
      m_sync[0] <= {b4, b3, b2, b1};
      for (int k = 1; k < SYNC_STAGES; k++) m_sync[k] <= m_sync[k-1];
      for (int i = 0; i < 4; i++) m_cnt[i] <= mt_cnt[i];
      m_d     <= mt_d;
      m_pend  <= mt_pend;
      m_valid <= mt_valid;
      m_id    <= mt_id;
      m_ovr   <= mt_ovr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_b(input logic [3:0] v);
    {b4, b3, b2, b1} = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!req_valid && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(req_valid), 32'd1);
  endtask

  task automatic release_all();
    set_b(4'b0000);
    tick = 1'b1;
    repeat (10) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] b;
    logic       tk;
    logic       rdy;
    logic [3:0] ed;
    logic       ev;
    logic [1:0] eid;
    logic       eo;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] b, input logic tk, input logic rdy,
                              input logic [3:0] ed, input logic ev, input logic [1:0] eid,
                              input logic eo);
    vec_t v;
    v.b = b; v.tk = tk; v.rdy = rdy; v.ed = ed; v.ev = ev; v.eid = eid; v.eo = eo;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_e, first_v, hs, exp_rise, n, first_hs, last_hs;
    logic stable;

    // b1 press with dense ticks, accept after one hold cycle, release,
    // then a 2-tick glitch on b2.
    for (int r = 0; r < 4; r++) tbl[r] = mk(4'h1, 1, 0, 4'h0, 0, 2'd0, 0);
    tbl[4] = mk(4'h1, 1, 0, 4'h1, 0, 2'd0, 0);
    tbl[5] = mk(4'h1, 1, 0, 4'h1, 1, 2'd0, 0);
    tbl[6] = mk(4'h1, 1, 0, 4'h1, 1, 2'd0, 0);
    tbl[7] = mk(4'h1, 1, 1, 4'h1, 0, 2'd0, 0);
    for (int r = 8; r < 12; r++) tbl[r] = mk(4'h0, 1, 1, 4'h1, 0, 2'd0, 0);
    tbl[12] = mk(4'h0, 1, 1, 4'h0, 0, 2'd0, 0);
    tbl[13] = mk(4'h2, 1, 1, 4'h0, 0, 2'd0, 0);
    tbl[14] = mk(4'h2, 1, 1, 4'h0, 0, 2'd0, 0);
    for (int r = 15; r < 19; r++) tbl[r] = mk(4'h0, 1, 1, 4'h0, 0, 2'd0, 0);

    // ---- reset ----
    rst = 1'b0;
    tick = 1'b0;
    req_ready = 1'b0;
    set_b(4'bxxxx);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_hold_valid", 32'(req_valid), 32'd0);
    check("rst_hold_d", 32'(d_all), 32'd0);
    @(negedge clk);
    set_b(4'b0000);
    rst = 1'b0;
    repeat (5) step();
    check("reset_d", 32'(d_all), 32'd0);
    check("reset_valid", 32'(req_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);

    // ---- table ----
    for (int r = 0; r < 19; r++) begin
      set_b(tbl[r].b);
      tick = tbl[r].tk;
      req_ready = tbl[r].rdy;
      step();
      check($sformatf("tbl%0d_d", r), 32'(d_all), 32'(tbl[r].ed));
      check($sformatf("tbl%0d_valid", r), 32'(req_valid), 32'(tbl[r].ev));
      if (tbl[r].ev) check($sformatf("tbl%0d_id", r), 32'(req_id), 32'(tbl[r].eid));
      check($sformatf("tbl%0d_ovr", r), 32'(overrun), 32'(tbl[r].eo));
    end

    // ---- debounce latency, tick every 4 clocks ----
    exp_rise = 0;
    n = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e % 4 == 0 && e >= SYNC_STAGES + 1) begin
        n++;
        if (n == DEBOUNCE_TICKS) exp_rise = e;
      end
    end
    rise_e = 0; first_v = 0; hs = 0;
    req_ready = 1'b1;
    set_b(4'h1);
    for (int e = 1; e <= 40; e++) begin
      tick = (e % 4 == 0);
      step();
      if (d1 && rise_e == 0) rise_e = e;
      if (req_valid) begin
        hs++;
        if (first_v == 0) begin
          first_v = e;
          check("lat_id", 32'(req_id), 32'd0);
        end
      end
    end
    check("lat_d1_rise", 32'(rise_e), 32'(exp_rise));
    check("lat_valid", 32'(first_v), 32'(exp_rise + 1));
    check("lat_one_req", 32'(hs), 32'd1);
    release_all();

    // ---- simultaneous press ----
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    first_hs = -1; last_hs = -1;
    req_ready = 1'b1;
    tick = 1'b1;
    set_b(4'hF);
    for (int e = 1; e <= 30; e++) begin
      step();
      if (req_valid) begin
        if (exp_q.size() > 0) begin
          check("simul_id", 32'(req_id), 32'(exp_q.pop_front()));
          if (first_hs < 0) first_hs = e;
          last_hs = e;
        end else begin
          check("simul_extra_valid", 32'(req_valid), 32'd0);
        end
      end
    end
    check("simul_left", 32'(exp_q.size()), 32'd0);
    check("simul_consecutive", 32'(last_hs - first_hs), 32'd3);
    check("simul_idle", 32'(req_valid), 32'd0);
    release_all();

    // ---- backpressure ----
    req_ready = 1'b0;
    set_b(4'b1100);
    wait_valid("bp_wait");
    check("bp_first_id", 32'(req_id), 32'd2);
    stable = 1'b1;
    repeat (10) begin
      step();
      if (!(req_valid === 1'b1 && req_id === 2'd2)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    req_ready = 1'b1;
    step();
    check("bp_next_valid", 32'(req_valid), 32'd1);
    check("bp_next_id", 32'(req_id), 32'd3);
    step();
    check("bp_drain", 32'(req_valid), 32'd0);
    release_all();

    // ---- overrun ----
    req_ready = 1'b0;
    set_b(4'b0001);
    wait_valid("ovr_wait_b1");
    check("ovr_b1_id", 32'(req_id), 32'd0);
    set_b(4'b1001);
    repeat (8) step();
    check("ovr_first_press", 32'(overrun), 32'd0);
    set_b(4'b0001);
    repeat (8) step();
    set_b(4'b1001);
    repeat (8) step();
    check("ovr_second_press", 32'(overrun), 32'd1);
    exp_q = '{2'd0, 2'd3};
    req_ready = 1'b1;
    for (int e = 0; e < 10; e++) begin
      if (req_valid) begin
        if (exp_q.size() > 0) check("ovr_id", 32'(req_id), 32'(exp_q.pop_front()));
        else check("ovr_extra_valid", 32'(req_valid), 32'd0);
      end
      step();
    end
    check("ovr_left", 32'(exp_q.size()), 32'd0);
    release_all();
    check("ovr_sticky", 32'(overrun), 32'd1);

    // ---- reset mid-offer ----
    req_ready = 1'b0;
    set_b(4'b0010);
    wait_valid("rst_offer_wait");
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(req_valid), 32'd0);
    check("rst_async_overrun", 32'(overrun), 32'd0);
    check("rst_async_d", 32'(d_all), 32'd0);
    @(negedge clk);
    set_b(4'b0000);
    rst = 1'b0;
    step();

    // ---- randomized against the model ----
    set_b(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          case (i)
            0: b1 = ~b1;
            1: b2 = ~b2;
            2: b3 = ~b3;
            default: b4 = ~b4;
          endcase
        end
      end
      tick = 1'($urandom_range(0, 1));
      req_ready = ($urandom_range(0, 2) != 0);
      step();
      check("rand_d", 32'(d_all), 32'(m_d));
      check("rand_valid", 32'(req_valid), 32'(m_valid));
      if (m_valid) check("rand_id", 32'(req_id), 32'(m_id));
      check("rand_overrun", 32'(overrun), 32'(m_ovr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
